// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 64-bit single-port memory between the fetch and
// load/store requesters. One transaction in flight (IDLE -> REQ -> RESP), data has
// fixed priority over fetch. Define MEM_ARB_STARVE_GUARD_EN to compile in a
// starvation guard that forces a fetch grant after STARVE_LIMIT lost IDLE cycles.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_resp_valid,
    output logic [31:0]       if_resp_inst,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    input  logic [7:0]        d_wmask,
    output logic              d_resp_valid,
    output logic [63:0]       d_resp_rdata,
    output logic              m_req_valid,
    input  logic              m_req_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_wen,
    output logic [63:0]       m_wdata,
    output logic [7:0]        m_wmask,
    input  logic              m_resp_valid,
    input  logic [63:0]       m_resp_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_owner;  // 0 = fetch, 1 = data
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [63:0]       r_wdata;
    logic [7:0]        r_wmask;
    logic              r_if_resp_valid;
    logic [31:0]       r_if_resp_inst;
    logic              r_d_resp_valid;
    logic [63:0]       r_d_resp_rdata;
    logic              w_fetch_force;
    logic              w_if_hs;
    logic              w_d_hs;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 2);

    logic [CntW-1:0] r_starve_cnt;

    assign w_fetch_force = (r_starve_cnt == CntW'(STARVE_LIMIT));

    // Count IDLE cycles in which a waiting fetch lost to data; saturate at the limit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!if_req_valid || w_if_hs) begin
            r_starve_cnt <= '0;
        end else if (w_d_hs && (r_starve_cnt != CntW'(STARVE_LIMIT))) begin
            r_starve_cnt <= r_starve_cnt + CntW'(1);
        end
    end
`else
    assign w_fetch_force = 1'b0;
`endif

    // Grant only in IDLE: data first unless the starvation guard forces fetch
    always_comb begin
        d_req_ready  = 1'b0;
        if_req_ready = 1'b0;
        if (r_state == StIdle) begin
            if (w_fetch_force) begin
                if_req_ready = if_req_valid;
            end else begin
                d_req_ready  = d_req_valid;
                if_req_ready = if_req_valid & ~d_req_valid;
            end
        end
    end

    assign w_if_hs = if_req_valid & if_req_ready;
    assign w_d_hs  = d_req_valid & d_req_ready;

    // Next-state logic; memory handshakes outside their state are ignored
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_if_hs || w_d_hs) w_state_next = StReq;
            StReq:   if (m_req_ready)       w_state_next = StResp;
            StResp:  if (m_resp_valid)      w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Latch the accepted request; fetch never writes
    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner <= 1'b0;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_d_hs) begin
            r_owner <= 1'b1;
            r_addr  <= d_addr;
            r_wen   <= d_wen;
            r_wdata <= d_wdata;
            r_wmask <= d_wmask;
        end else if (w_if_hs) begin
            r_owner <= 1'b0;
            r_addr  <= if_addr;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end
    end

    // Registered response: one-cycle pulse to the owner, non-owner data holds
    always_ff @(posedge clock) begin
        if (reset) begin
            r_if_resp_valid <= 1'b0;
            r_if_resp_inst  <= '0;
            r_d_resp_valid  <= 1'b0;
            r_d_resp_rdata  <= '0;
        end else begin
            r_if_resp_valid <= 1'b0;
            r_d_resp_valid  <= 1'b0;
            if ((r_state == StResp) && m_resp_valid) begin
                if (r_owner) begin
                    r_d_resp_valid <= 1'b1;
                    r_d_resp_rdata <= r_wen ? 64'd0 : m_resp_rdata;
                end else begin
                    r_if_resp_valid <= 1'b1;
                    r_if_resp_inst  <= r_addr[2] ? m_resp_rdata[63:32] : m_resp_rdata[31:0];
                end
            end
        end
    end

    assign m_req_valid   = (r_state == StReq);
    assign m_addr        = {r_addr[ADDR_W-1:3], 3'b000};
    assign m_wen         = r_wen;
    assign m_wdata       = r_wdata;
    assign m_wmask       = r_wmask;
    assign busy          = (r_state != StIdle);
    assign if_resp_valid = r_if_resp_valid;
    assign if_resp_inst  = r_if_resp_inst;
    assign d_resp_valid  = r_d_resp_valid;
    assign d_resp_rdata  = r_d_resp_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 64;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned LIMIT = 2;
    localparam bit          GUARD = 1'b1;
`else
    localparam int unsigned LIMIT = 8;
    localparam bit          GUARD = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          if_req_valid;
    logic          if_req_ready;
    logic [AW-1:0] if_addr;
    logic          if_resp_valid;
    logic [31:0]   if_resp_inst;
    logic          d_req_valid;
    logic          d_req_ready;
    logic          d_wen;
    logic [AW-1:0] d_addr;
    logic [63:0]   d_wdata;
    logic [7:0]    d_wmask;
    logic          d_resp_valid;
    logic [63:0]   d_resp_rdata;
    logic          m_req_valid;
    logic          m_req_ready;
    logic [AW-1:0] m_addr;
    logic          m_wen;
    logic [63:0]   m_wdata;
    logic [7:0]    m_wmask;
    logic          m_resp_valid;
    logic [63:0]   m_resp_rdata;
    logic          busy;

    mem_port_arbiter #(
        .ADDR_W       (AW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_resp_valid (if_resp_valid),
        .if_resp_inst  (if_resp_inst),
        .d_req_valid   (d_req_valid),
        .d_req_ready   (d_req_ready),
        .d_wen         (d_wen),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_wmask       (d_wmask),
        .d_resp_valid  (d_resp_valid),
        .d_resp_rdata  (d_resp_rdata),
        .m_req_valid   (m_req_valid),
        .m_req_ready   (m_req_ready),
        .m_addr        (m_addr),
        .m_wen         (m_wen),
        .m_wdata       (m_wdata),
        .m_wmask       (m_wmask),
        .m_resp_valid  (m_resp_valid),
        .m_resp_rdata  (m_resp_rdata),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the one outstanding transaction: phase 0 = none, 1 = asking memory,
    // 2 = awaiting memory data.
    int          md_ph;
    bit          md_own;
    logic [63:0] md_addr;
    bit          md_wen;
    logic [63:0] md_wdata;
    logic [7:0]  md_wmask;
    bit          md_ifrv;
    logic [31:0] md_ifinst;
    bit          md_drv;
    logic [63:0] md_drdata;
    int          md_cnt;
    bit          e_if_ready;
    bit          e_d_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        md_ph = 0; md_own = 0; md_addr = '0; md_wen = 0; md_wdata = '0; md_wmask = '0;
        md_ifrv = 0; md_ifinst = '0; md_drv = 0; md_drdata = '0; md_cnt = 0;
    endtask

    // Compare every DUT output with the model for the current cycle
    task automatic check_cycle();
        bit force_fetch;
        #1;
        force_fetch = GUARD && (md_cnt == int'(LIMIT));
        e_d_ready   = (md_ph == 0) && d_req_valid && !force_fetch;
        e_if_ready  = (md_ph == 0) && if_req_valid && (force_fetch || !d_req_valid);
        chk("if_req_ready", if_req_ready, e_if_ready);
        chk("d_req_ready", d_req_ready, e_d_ready);
        chk("busy", busy, md_ph != 0);
        chk("m_req_valid", m_req_valid, md_ph == 1);
        chk("m_addr", m_addr, {md_addr[63:3], 3'b000});
        chk("m_wen", m_wen, md_wen);
        chk("m_wmask", m_wmask, md_wmask);
        if (md_own) chk("m_wdata", m_wdata, md_wdata);
        chk("if_resp_valid", if_resp_valid, md_ifrv);
        chk("if_resp_inst", if_resp_inst, md_ifinst);
        chk("d_resp_valid", d_resp_valid, md_drv);
        chk("d_resp_rdata", d_resp_rdata, md_drdata);
    endtask

    // Move the model across the clock edge using the inputs driven this cycle
    task automatic advance();
        if (reset) begin
            model_clear();
        end else begin
            md_ifrv = 0;
            md_drv  = 0;
            if (md_ph == 0) begin
                if (e_d_ready) begin
                    md_own = 1; md_addr = d_addr; md_wen = d_wen;
                    md_wdata = d_wdata; md_wmask = d_wmask; md_ph = 1;
                end else if (e_if_ready) begin
                    md_own = 0; md_addr = if_addr; md_wen = 0;
                    md_wdata = '0; md_wmask = '0; md_ph = 1;
                end
                if (!if_req_valid || e_if_ready) md_cnt = 0;
                else if (e_d_ready && md_cnt < int'(LIMIT)) md_cnt++;
            end else begin
                if (!if_req_valid) md_cnt = 0;
                if (md_ph == 1) begin
                    if (m_req_ready) md_ph = 2;
                end else if (m_resp_valid) begin
                    md_ph = 0;
                    if (md_own) begin
                        md_drv    = 1;
                        md_drdata = md_wen ? 64'd0 : m_resp_rdata;
                    end else begin
                        md_ifrv   = 1;
                        md_ifinst = md_addr[2] ? m_resp_rdata[63:32] : m_resp_rdata[31:0];
                    end
                end
            end
        end
        @(negedge clock);
    endtask

    // Clock edge, then requesters withdraw whatever was accepted
    task automatic finish_cycle();
        bit acc_if;
        bit acc_d;
        acc_if = e_if_ready && !reset;
        acc_d  = e_d_ready && !reset;
        advance();
        if (acc_if) if_req_valid = 1'b0;
        if (acc_d)  d_req_valid  = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            check_cycle();
            finish_cycle();
        end
    endtask

    initial begin
        int nd;
        int ni;
        int dcyc;
        int icyc;
        int first;

        reset = 1'b1;
        if_req_valid = 0; if_addr = '0;
        d_req_valid = 0; d_wen = 0; d_addr = '0; d_wdata = '0; d_wmask = '0;
        m_req_ready = 0; m_resp_valid = 0; m_resp_rdata = '0;
        model_clear();
        @(negedge clock);

        // Reset state
        check_cycle();
        chk("reset_busy", busy, 0);
        chk("reset_m_req_valid", m_req_valid, 0);
        chk("reset_m_addr", m_addr, 0);
        chk("reset_d_resp_rdata", d_resp_rdata, 0);
        finish_cycle();
        reset = 1'b0;

        // Fetch only, minimum latency
        m_req_ready = 1; m_resp_valid = 1; m_resp_rdata = 64'h1122_3344_5566_7788;
        if_req_valid = 1; if_addr = 64'h8000_0004;
        check_cycle(); chk("fetch_grant", if_req_ready, 1); finish_cycle();
        check_cycle();
        chk("fetch_m_req_valid", m_req_valid, 1);
        chk("fetch_m_addr", m_addr, 64'h8000_0000);
        chk("fetch_m_wen", m_wen, 0);
        finish_cycle();
        check_cycle(); finish_cycle();
        check_cycle();
        chk("fetch_resp_valid", if_resp_valid, 1);
        chk("fetch_inst", if_resp_inst, 32'h1122_3344);
        finish_cycle();

        // Store
        d_req_valid = 1; d_wen = 1; d_addr = 64'h8000_1008;
        d_wdata = 64'hDEAD_BEEF_0000_0000; d_wmask = 8'hF0;
        check_cycle(); chk("store_grant", d_req_ready, 1); finish_cycle();
        check_cycle();
        chk("store_m_wen", m_wen, 1);
        chk("store_m_wmask", m_wmask, 8'hF0);
        chk("store_m_wdata", m_wdata, 64'hDEAD_BEEF_0000_0000);
        chk("store_m_addr", m_addr, 64'h8000_1008);
        finish_cycle();
        check_cycle(); finish_cycle();
        check_cycle();
        chk("store_resp_valid", d_resp_valid, 1);
        chk("store_rdata_zero", d_resp_rdata, 0);
        chk("store_no_fetch_resp", if_resp_valid, 0);
        finish_cycle();

        // Contention: data load served first, fetch at the next IDLE
        d_req_valid = 1; d_wen = 0; d_addr = 64'h8000_0010; d_wmask = 8'h00;
        if_req_valid = 1; if_addr = 64'h8000_0008;
        nd = 0; ni = 0; dcyc = 99; icyc = 99;
        for (int k = 0; k < 9; k++) begin
            check_cycle();
            if (k == 0) chk("contention_fetch_waits", if_req_ready, 0);
            if (d_resp_valid) begin
                nd++; dcyc = k;
                chk("contention_load_data", d_resp_rdata, 64'h1122_3344_5566_7788);
            end
            if (if_resp_valid) begin
                ni++; icyc = k;
                chk("contention_fetch_inst", if_resp_inst, 32'h5566_7788);
            end
            finish_cycle();
        end
        chk("contention_d_pulses", nd, 1);
        chk("contention_if_pulses", ni, 1);
        chk("contention_d_cycle", dcyc, 3);
        chk("contention_if_cycle", icyc, 6);

        // Memory stalls request for 5 cycles with both requesters waiting
        m_req_ready = 0;
        if_req_valid = 1; if_addr = 64'h8000_0024;
        check_cycle(); finish_cycle();
        if_req_valid = 1; if_addr = 64'h8000_0030;
        d_req_valid = 1; d_wen = 0; d_addr = 64'h8000_0040;
        for (int k = 0; k < 5; k++) begin
            check_cycle();
            chk("stall_m_req_valid", m_req_valid, 1);
            chk("stall_m_addr", m_addr, 64'h8000_0020);
            chk("stall_busy", busy, 1);
            chk("stall_if_ready", if_req_ready, 0);
            chk("stall_d_ready", d_req_ready, 0);
            finish_cycle();
        end
        m_req_ready = 1;
        drain(12);

        // Reset while awaiting memory data; late response is ignored
        m_req_ready = 1; m_resp_valid = 0;
        if_req_valid = 1; if_addr = 64'h8000_0044;
        drain(2);
        reset = 1;
        check_cycle(); chk("rst_in_resp_busy", busy, 1); finish_cycle();
        reset = 0; m_resp_valid = 1;
        for (int k = 0; k < 3; k++) begin
            check_cycle();
            chk("rst_busy", busy, 0);
            chk("rst_if_resp_valid", if_resp_valid, 0);
            chk("rst_m_req_valid", m_req_valid, 0);
            chk("rst_m_addr", m_addr, 0);
            chk("rst_if_inst", if_resp_inst, 0);
            finish_cycle();
        end

        // Starvation: data continuously requesting, fetch waiting
        if_req_valid = 1; if_addr = 64'h8000_0050;
        d_req_valid = 1; d_wen = 0; d_addr = 64'h8000_0060;
        first = 99;
        for (int k = 0; k < 15; k++) begin
            check_cycle();
            if (if_req_ready && first == 99) first = k;
            finish_cycle();
            d_req_valid = 1;
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk("starve_first_fetch_grant", first, 6);
`else
        chk("starve_fetch_never_granted", first, 99);
`endif
        if_req_valid = 0; d_req_valid = 0;
        drain(6);

        // Randomized traffic with random memory timing and occasional reset
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            if (!if_req_valid && $urandom_range(0, 1) == 1) begin
                if_req_valid = 1;
                if_addr = {$urandom, $urandom} & ~64'h3;
            end
            if (!d_req_valid && $urandom_range(0, 2) == 0) begin
                d_req_valid = 1;
                d_wen = 1'($urandom_range(0, 1));
                d_addr = {$urandom, $urandom};
                d_wdata = {$urandom, $urandom};
                d_wmask = 8'($urandom);
            end
            m_req_ready = ($urandom_range(0, 2) != 0);
            m_resp_valid = ($urandom_range(0, 2) == 0);
            m_resp_rdata = {$urandom, $urandom};
            check_cycle();
            finish_cycle();
        end
        reset = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 64-bit single-port memory between the instruction-fetch requester and the load/store requester.
- Sits between the fetch logic and the memory, and between the load/store logic and the same memory.
- Holds at most one transaction in flight. Uses valid/ready request handshakes and a registered response return.
- Data accesses have fixed priority over fetch. A starvation guard, described under Optional Feature, can be compiled in.

Parameters:
- ADDR_W, 64, address width of requesters and memory.
- STARVE_LIMIT, 8, consecutive lost-arbitration cycles before fetch is forced to win. Used only with the optional feature.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- if_req_valid  input  1  fetch request present
- if_req_ready  output  1  fetch request accepted this cycle
- if_addr  input  ADDR_W  fetch byte address, 4-byte aligned
- if_resp_valid  output  1  fetch data valid, 1-cycle pulse
- if_resp_inst  output  32  fetched instruction
- d_req_valid  input  1  data request present
- d_req_ready  output  1  data request accepted this cycle
- d_wen  input  1  1 = store, 0 = load
- d_addr  input  ADDR_W  data byte address
- d_wdata  input  64  store data, already lane-aligned
- d_wmask  input  8  store byte enables
- d_resp_valid  output  1  load data or store acknowledge, 1-cycle pulse
- d_resp_rdata  output  64  raw 64-bit memory word; zero for stores
- m_req_valid  output  1  memory request
- m_req_ready  input  1  memory accepts request
- m_addr  output  ADDR_W  8-byte-aligned address
- m_wen  output  1  memory write
- m_wdata  output  64  write data
- m_wmask  output  8  write byte enables
- m_resp_valid  input  1  memory response
- m_resp_rdata  input  64  memory read data
- busy  output  1  state not IDLE

Behaviour:
- States and transitions:
  - IDLE: accept a request; go to REQ on an accepted handshake.
  - REQ: drive the memory request; go to RESP on m_req_ready.
  - RESP: wait for the memory response; go to IDLE on m_resp_valid.
- Reset values: state=IDLE; all resp_valid=0; resp data=0; m_req_valid=0; m_addr/m_wdata/m_wmask/m_wen=0; busy=0; starvation counter=0.
- Grant, combinational, only in IDLE:
  - d_req_ready = d_req_valid.
  - if_req_ready = if_req_valid & ~d_req_valid.
  - Both ready outputs are 0 in REQ and RESP.
- On handshake, latch into registers:
  - owner bit (0 = fetch, 1 = data), address, wen, wdata, wmask;
  - fetch forces wen=0 and wmask=0;
  - addr bit 2 is kept as the fetch word select.
- Memory request outputs:
  - m_req_valid=1 exactly while in REQ.
  - m_addr = {latched_addr[ADDR_W-1:3], 3'b0}.
  - Other m_* outputs come from the latched registers and stay stable until m_req_ready.
- Response:
  - On m_resp_valid in RESP, the owner's resp_valid goes to 1 in the next cycle, for exactly 1 cycle.
  - if_resp_inst = sel ? rdata[63:32] : rdata[31:0].
  - d_resp_rdata = rdata for loads and 0 for stores.
  - The non-owner's resp_valid stays 0 and its data output holds its previous value.
- Spurious memory traffic: m_resp_valid outside RESP is ignored. m_req_ready outside REQ is ignored.
- Minimum latency with memory always ready and responding in the cycle after the request:
  - handshake at cycle t;
  - m_req_valid at t+1;
  - m_resp_valid at t+2;
  - resp_valid and a new handshake possible at t+3.
- Requesters must hold valid and payload stable until ready. The arbiter does not register unaccepted requests.
- Simultaneous fetch and data requests: data wins; fetch waits for the next IDLE.
- Reset during REQ or RESP: the transaction is abandoned, no response pulse is produced, and a late m_resp_valid is ignored.
- Back-to-back requests always pass through IDLE. There is no pipelining; throughput is at most 1 transaction per 3 cycles.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - a counter counts IDLE cycles in which if_req_valid=1 and the fetch lost to data; it saturates at STARVE_LIMIT;
  - when the count equals STARVE_LIMIT, the IDLE grant goes to fetch (if_req_ready=if_req_valid, d_req_ready=0);
  - the counter clears on a fetch handshake or when if_req_valid=0.
- Undefined: no counter; fixed data priority as above. The STARVE_LIMIT parameter is unused.

Test Plan:
- Fetch only: if_addr=0x80000004, memory returns 0x11223344_55667788 → if_resp_inst=0x11223344 at t+3, m_addr=0x80000000, m_wen=0.
- Store: d_wen=1, d_addr=0x80001008, wdata=0xDEADBEEF00000000, wmask=0xF0 → m_wen=1, m_wmask=0xF0, d_resp_valid pulse with rdata=0, if_resp_valid stays 0.
- Contention: both valid in the same cycle with a 0x80000010 data load → data served first; fetch accepted at the following IDLE; exactly one resp pulse to each requester, in that order.
- m_req_ready held 0 for 5 cycles → m_req_valid and m_* stay stable, both ready outputs 0, busy=1 throughout.
- Reset asserted in RESP, then m_resp_valid pulses → no resp_valid, state IDLE, all outputs at reset values.
- Guard on (macro defined, STARVE_LIMIT=2): d_req_valid and if_req_valid held high continuously → after 2 lost IDLE cycles, fetch is granted despite the pending data request. Guard off: fetch is never granted under the same stimulus.
